// File: rtl/fp_decode_accum.sv
// fp_decode_accum
//   Decodes 8-bit FP samples (S, E[2:0], F[3:0]) from the converter stage
//   back to signed linear values (+/-F * 2^E). It sums N samples into a
//   saturating signed accumulator and presents each block sum on an output
//   valid/ready handshake.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous abort of the current block / pending sum
//   in_valid/in_ready   sample handshake; in_ready depends on state only
//   in_s, in_e, in_f    FP sample fields
//   out_valid/out_ready block-sum handshake (out_valid is registered)
//   out_sum, out_sat    block sum, and a flag showing saturation in that block
//   out_cnt             samples accepted so far in the current block
module fp_decode_accum #(
  parameter int N     = 8,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [2:0]       in_e,
  input  logic [3:0]       in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic [7:0]       out_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0]       LAST  = 8'(N - 1);
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             osat_q, osat_d;

  // Decode: the magnitude fits in 11 bits (max 15<<7 = 1920).
  logic [10:0]      mag;
  logic [ACC_W:0]   mag_x, term, nxt;
  logic             ovf;
  logic [ACC_W-1:0] clamped;

  assign mag   = {7'b0, in_f} << in_e;
  assign mag_x = {{(ACC_W-10){1'b0}}, mag};
  assign term  = in_s ? -mag_x : mag_x;

  // One guard bit is enough. |term| < 2^11 <= 2^(ACC_W-1), so the sum of the
  // accumulator and one term stays inside the ACC_W+1 range.
  assign nxt     = {acc_q[ACC_W-1], acc_q} + term;
  assign ovf     = nxt[ACC_W] ^ nxt[ACC_W-1];
  assign clamped = ovf ? (nxt[ACC_W] ? MIN_V : MAX_V) : nxt[ACC_W-1:0];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    sum_d   = sum_q;
    osat_d  = osat_q;
    if (clear) begin
      // clear wins over any accept or output handshake in the same cycle.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_q == LAST) begin
              sum_d   = clamped;
              osat_d  = sat_q | ovf;
              state_d = HOLD;
              acc_d   = '0;
              cnt_d   = '0;
              sat_d   = 1'b0;
            end else begin
              acc_d = clamped;
              cnt_d = cnt_q + 8'd1;
              sat_d = sat_q | ovf;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      sum_q   <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      sum_q   <= sum_d;
      osat_q  <= osat_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_sat   = osat_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_fp_decode_accum.sv
// Directed bench for fp_decode_accum. Instance "a" uses the default ACC_W=16.
// Instance "b" uses ACC_W=12, so the same stimulus also reaches saturation.
// Expected block sums come from an integer model and are queued as each
// block completes. They are popped and compared when the DUT presents the sum.
module tb_fp_decode_accum;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic        in_valid = 1'b0, in_s = 1'b0, out_ready = 1'b0;
  logic [2:0]  in_e = '0;
  logic [3:0]  in_f = '0;
  logic        rdy_a, vld_a, sat_a, rdy_b, vld_b, sat_b;
  logic [15:0] sum_a;
  logic [11:0] sum_b;
  logic [7:0]  cnt_a, cnt_b;

  always #5 clk = ~clk;

  fp_decode_accum #(.N(8), .ACC_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_a),
    .in_s(in_s), .in_e(in_e), .in_f(in_f), .out_valid(vld_a), .out_ready(out_ready),
    .out_sum(sum_a), .out_sat(sat_a), .out_cnt(cnt_a));

  fp_decode_accum #(.N(8), .ACC_W(12)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(rdy_b),
    .in_s(in_s), .in_e(in_e), .in_f(in_f), .out_valid(vld_b), .out_ready(out_ready),
    .out_sum(sum_b), .out_sat(sat_b), .out_cnt(cnt_b));

  typedef struct {
    int sum_a;
    bit sat_a;
    int sum_b;
    bit sat_b;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   m_acc_a, m_acc_b, m_cnt;
  bit   m_sat_a, m_sat_b;

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int clampw(int v, int w);
    int hi = (1 <<< (w - 1)) - 1;
    int lo = -(1 <<< (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_clear();
    m_acc_a = 0; m_acc_b = 0; m_cnt = 0; m_sat_a = 0; m_sat_b = 0;
  endtask

  task automatic model_accept(bit s, int e, int f);
    int t = f << e;
    int na, nb;
    if (s) t = -t;
    na = m_acc_a + t;
    nb = m_acc_b + t;
    if (clampw(na, 16) != na) m_sat_a = 1;
    if (clampw(nb, 12) != nb) m_sat_b = 1;
    m_acc_a = clampw(na, 16);
    m_acc_b = clampw(nb, 12);
    m_cnt++;
    if (m_cnt == 8) begin
      sb.push_back('{m_acc_a, m_sat_a, m_acc_b, m_sat_b});
      model_clear();
    end
  endtask

  // Entered and left at a negedge. Drives one cycle of a sample; the model
  // follows whatever in_ready showed before the edge.
  task automatic drive(bit s, int e, int f, bit clr = 1'b0);
    bit rdy;
    in_valid = 1'b1; in_s = s; in_e = 3'(e); in_f = 4'(f); clear = clr;
    rdy = rdy_a;
    @(negedge clk);
    if (clr) model_clear();
    else if (rdy) model_accept(s, e, f);
    in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic take_sum(string tag);
    exp_t e;
    chk({tag, ".valid_a"}, vld_a, 1);
    chk({tag, ".valid_b"}, vld_b, 1);
    chk({tag, ".ready"}, rdy_a, 0);
    chk({tag, ".sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".sum_a"}, $signed(sum_a), e.sum_a);
      chk({tag, ".sat_a"}, sat_a, e.sat_a);
      chk({tag, ".sum_b"}, $signed(sum_b), e.sum_b);
      chk({tag, ".sat_b"}, sat_b, e.sat_b);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".ready_after"}, rdy_a, 1);
    chk({tag, ".valid_after"}, vld_a, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    @(negedge clk);
    chk("rst.ready", rdy_a, 1);
    chk("rst.valid", vld_a, 0);
    chk("rst.sum", $signed(sum_a), 0);
    chk("rst.sat", sat_a, 0);
    chk("rst.cnt", cnt_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic block: 8 x (+1). The sum must appear right after the 8th edge.
    repeat (8) drive(0, 0, 1);
    chk("basic.const", $signed(sum_a), 8);
    take_sum("basic");

    // Mixed signs, including negative zero.
    drive(0, 7, 15); drive(1, 7, 15); drive(0, 3, 8); drive(1, 0, 3);
    drive(0, 0, 0);  drive(1, 0, 0);  drive(0, 0, 0);
    chk("mixed.cnt7", cnt_a, 7);
    drive(0, 0, 0);
    chk("mixed.const", $signed(sum_a), 61);
    take_sum("mixed");

    // Asynchronous reset in the middle of a block.
    repeat (3) drive(0, 0, 1);
    chk("arst.cnt_before", cnt_a, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", vld_a, 0);
    chk("arst.ready", rdy_a, 1);
    chk("arst.sum", $signed(sum_a), 0);
    chk("arst.cnt", cnt_a, 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Backpressure: samples offered during HOLD are ignored.
    repeat (8) drive(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 7, 15);
      chk("bp.ready", rdy_a, 0);
      chk("bp.valid", vld_a, 1);
      chk("bp.cnt", cnt_a, 0);
      chk("bp.sum_stable", $signed(sum_a), 8);
    end
    take_sum("bp");
    repeat (8) drive(0, 1, 2);
    chk("bp2.const", $signed(sum_a), 32);
    take_sum("bp2");

    // Saturation (the 12-bit instance clamps; the 16-bit one does not).
    repeat (8) drive(0, 7, 15);
    chk("satp.const", $signed(sum_b), 2047);
    take_sum("sat_pos");
    repeat (8) drive(1, 7, 15);
    chk("satn.const", $signed(sum_b), -2048);
    take_sum("sat_neg");
    repeat (2) drive(0, 7, 15);
    repeat (6) drive(1, 0, 1);
    chk("satoff.const", $signed(sum_b), 2041);
    take_sum("sat_off");

    // Clear in ACCUM, arriving together with a valid sample.
    repeat (3) drive(0, 0, 5);
    chk("clr.cnt_before", cnt_a, 3);
    drive(0, 0, 5, 1'b1);
    chk("clr.cnt", cnt_a, 0);
    repeat (8) drive(0, 0, 1);
    chk("clr.const", $signed(sum_a), 8);
    take_sum("clr_blk");

    // Clear in HOLD, issued together with out_ready: the pending sum is dropped.
    repeat (8) drive(0, 0, 2);
    chk("clrh.valid_before", vld_a, 1);
    clear = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    chk("clrh.valid", vld_a, 0);
    chk("clrh.ready", rdy_a, 1);
    chk("clrh.cnt", cnt_a, 0);
    repeat (8) drive(0, 0, 3);
    take_sum("post_clr");

    chk("sb.empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_decode_accum.md
Name: fp_decode_accum

Overview:
Downstream consumer of the 12-bit-to-8-bit floating-point converter stage (S, E[2:0], F[3:0]). Accepts a stream of FP samples over a valid/ready handshake and decodes each back to a signed linear value, (S ? -1 : +1) * F * 2^E. Accumulates N samples into a saturating signed sum, then presents the block sum on an output valid/ready handshake. It sits between the converter and the display/readout logic.

Parameters:
N, 8, samples per accumulation block (2..255)
ACC_W, 16, accumulator/result width in bits, signed (12..24)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: discard partial block, return to ACCUM
in_valid  input  1  FP sample present
in_ready  output  1  block can accept a sample
in_s  input  1  sign of sample
in_e  input  3  exponent of sample
in_f  input  4  significand of sample
out_valid  output  1  block sum available
out_ready  input  1  consumer takes the sum
out_sum  output  ACC_W  signed block sum, two's complement
out_sat  output  1  saturation occurred at least once during the block
out_cnt  output  8  samples accepted in the current block

Behaviour:
- Reset (rst_n=0, async): state=ACCUM, acc=0, count=0, out_sum=0, out_sat=0, out_valid=0, in_ready=1, out_cnt=0. Reset mid-block discards all partial data.
- Decode (combinational): mag = {7'b0,in_f} << in_e, 11-bit unsigned, max 15<<7 = 1920. term = in_s ? -mag : mag, sign-extended to ACC_W+1. S=1 with mag=0 gives term 0.
- Accept: in_valid && in_ready at a rising edge.
- States: ACCUM and HOLD.
- ACCUM: in_ready=1, out_valid=0.
  - On accept: nxt = acc + term, computed at ACC_W+1 bits.
  - Clamp nxt to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Set the sticky sat flag if clamped.
  - count increments on each accept.
  - On the Nth accept, the same edge performs all of: out_sum = clamped nxt, out_sat = sticky flag including this sample, state -> HOLD, out_valid=1, acc=0, count=0, sticky flag=0.
  - out_valid is high in the cycle immediately after the Nth accept. Latency is 0 extra cycles after the last sample edge.
- HOLD: in_ready=0. in_valid and the sample inputs are ignored. out_sum and out_sat are held stable while out_valid=1.
  - When out_valid && out_ready at an edge: out_valid=0 and state -> ACCUM. in_ready=1 from the next cycle.
  - No sample is accepted in the cycle the sum is taken.
- out_cnt mirrors count. It reads 0 in HOLD.
- clear=1:
  - In ACCUM: acc=0, count=0, sticky flag=0. Any accept that cycle is discarded.
  - In HOLD: out_valid=0, state -> ACCUM, pending sum dropped.
  - clear has priority over accept and over an out_ready handshake.
- out_sum and out_sat keep their last value after the handshake. Only reset zeroes them.
- Saturation is applied per add: once clamped, later opposite-sign terms move the value off the rail (no sticky value, only the sticky flag).
- in_ready depends only on state, never combinationally on in_valid. out_valid is registered.

Test Plan:
- Reset check: assert rst_n=0 mid-block after 3 accepts -> out_valid=0, in_ready=1, out_sum=0, out_cnt=0 immediately, without waiting for a clock edge.
- Basic block (N=8): 8 samples S=0,E=0,F=1, in_valid continuous -> out_valid=1 the cycle after the 8th accept, out_sum=8, out_sat=0.
- Mixed signs: (0,7,15), (1,7,15), (0,3,8), (1,0,3), then (0,0,0), (1,0,0), (0,0,0), (0,0,0) -> out_sum=61 (+1920-1920+64-3), out_sat=0.
- Backpressure: complete a block, hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0, out_sum stable, no count change. Then pulse out_ready -> next cycle in_ready=1; the next block of 8x(0,1,2) yields 32.
- Saturation (ACC_W=12): 8x(0,7,15) -> out_sum=2047, out_sat=1. 8x(1,7,15) -> out_sum=-2048, out_sat=1. 2x(0,7,15) followed by 6x(1,0,1) -> out_sum=2041, out_sat=1.
- Clear: accept 3 samples (0,0,5), assert clear together with an in_valid sample -> out_cnt=0, sample dropped; the next 8x(0,0,1) give out_sum=8. Assert clear in HOLD with out_ready=1 -> out_valid=0, sum dropped.
